// File: rtl/mnist_dlayer1_sched.sv
// mnist_dlayer1_sched: dense-layer pass sequencer.
// On start it latches one activation vector and streams N_NODES weight rows and
// biases through a single pipelined dense node, one neuron per cycle, writing
// each node result to the layer result buffer in neuron order.
// Optional feature: define MNIST_SCHED_ARGMAX_EN to add a running argmax over
// the written results (max_idx / max_val ports).
module mnist_dlayer1_sched #(
  parameter int N_NODES  = 64,
  parameter int AW       = 6,
  parameter int NODE_LAT = 7
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [8191:0]     x_in,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic              w_rd,
  output logic [AW-1:0]     w_addr,
  input  logic [8191:0]     w_data,
  input  logic [31:0]       b_data,
  output logic              node_valid,
  output logic [8191:0]     node_a,
  output logic [8191:0]     node_b,
  output logic [31:0]       node_bias,
  input  logic [31:0]       node_c,
  input  logic              node_v,
  output logic              res_wr,
  output logic [AW-1:0]     res_addr,
  output logic [31:0]       res_data
`ifdef MNIST_SCHED_ARGMAX_EN
  ,
  output logic [AW-1:0]     max_idx,
  output logic [31:0]       max_val
`endif
);

  // Reject parameter sets the counters cannot represent.
  if (N_NODES < 1 || (2 ** AW) < N_NODES || NODE_LAT < 0) begin : g_param_check
    $error("mnist_dlayer1_sched: invalid N_NODES/AW/NODE_LAT");
  end

  localparam logic [AW-1:0] LAST_RD = AW'(N_NODES - 1);
  // Write count carries one extra bit so it can reach N_NODES when N_NODES == 2**AW.
  localparam logic [AW:0]   N_WR    = (AW + 1)'(N_NODES);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_DONE} state_t;

  state_t          state_q;
  logic [AW-1:0]   rd_cnt_q;
  logic [AW:0]     wr_cnt_q, wr_cnt_d;
  logic            busy_q, done_q, err_q, w_rd_q, node_valid_q;
  logic [8191:0]   x_q;
  logic            active, wr_ok, wr_bad;

  // Writeback qualification: a node result is accepted only mid-pass and below the cap.
  always_comb begin
    active   = (state_q == S_ISSUE) || (state_q == S_DRAIN);
    wr_ok    = node_v && active && (wr_cnt_q < N_WR);
    wr_bad   = node_v && !wr_ok;
    wr_cnt_d = wr_ok ? wr_cnt_q + 1'b1 : wr_cnt_q;
  end

  // Pass FSM with registered control outputs and the feed-path valid delay.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      rd_cnt_q     <= '0;
      wr_cnt_q     <= '0;
      x_q          <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
      w_rd_q       <= 1'b0;
      node_valid_q <= 1'b0;
    end else begin
      wr_cnt_q     <= wr_cnt_d;
      node_valid_q <= w_rd_q;
      done_q       <= 1'b0;
      if (wr_bad) err_q <= 1'b1;
      unique case (state_q)
        S_IDLE: begin
          if (start) begin
            state_q  <= S_ISSUE;
            x_q      <= x_in;
            rd_cnt_q <= '0;
            wr_cnt_q <= '0;
            err_q    <= wr_bad;
            busy_q   <= 1'b1;
            w_rd_q   <= 1'b1;
          end
        end
        S_ISSUE: begin
          if (rd_cnt_q == LAST_RD) begin
            state_q <= S_DRAIN;
            w_rd_q  <= 1'b0;
          end else begin
            rd_cnt_q <= rd_cnt_q + 1'b1;
          end
        end
        S_DRAIN: begin
          // Look at the post-write count so done lands the cycle after the last write.
          if (wr_cnt_d == N_WR) begin
            state_q <= S_DONE;
            done_q  <= 1'b1;
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign err        = err_q;
  assign w_rd       = w_rd_q;
  assign w_addr     = rd_cnt_q;
  assign node_valid = node_valid_q;
  assign node_a     = x_q;
  // Memory data is forwarded in its valid cycle and held at zero otherwise.
  assign node_b     = node_valid_q ? w_data : '0;
  assign node_bias  = node_valid_q ? b_data : '0;
  assign res_wr     = wr_ok;
  assign res_addr   = wr_cnt_q[AW-1:0];
  assign res_data   = wr_ok ? node_c : '0;

`ifdef MNIST_SCHED_ARGMAX_EN
  logic signed [31:0] max_val_q;
  logic [AW-1:0]      max_idx_q;

  // Running argmax; strict signed greater-than keeps the lowest index on ties.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      max_val_q <= '0;
      max_idx_q <= '0;
    end else if (state_q == S_IDLE && start) begin
      max_val_q <= 32'sh8000_0000;
      max_idx_q <= '0;
    end else if (wr_ok && ($signed(node_c) > max_val_q)) begin
      max_val_q <= node_c;
      max_idx_q <= wr_cnt_q[AW-1:0];
    end
  end

  assign max_val = max_val_q;
  assign max_idx = max_idx_q;
`endif

endmodule

// File: tb/tb_mnist_dlayer1_sched.sv
// Bench for mnist_dlayer1_sched: N_NODES=4 main instance plus an N_NODES=1
// instance, ideal 1-cycle weight memory and a fixed-latency fake dense node.
`timescale 1ns/1ps
module tb_mnist_dlayer1_sched;
  localparam int N     = 4;
  localparam int AW    = 2;
  localparam int L     = 7;
  localparam int DW    = 8192;
  localparam int TDONE = N + L + 2;

  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, inj_v = 1'b0;
  logic [DW-1:0] x_in = '0;

  logic busy, done, err, w_rd, node_valid, node_v, res_wr;
  logic [AW-1:0] w_addr, res_addr;
  logic [DW-1:0] w_data, node_a, node_b;
  logic [31:0] b_data, node_bias, node_c, res_data;

  logic busy1, done1, err1, w_rd1, node_valid1, node_v1, res_wr1;
  logic [0:0] w_addr1, res_addr1;
  logic [DW-1:0] w_data1, node_a1, node_b1;
  logic [31:0] b_data1, node_bias1, node_c1, res_data1;
`ifdef MNIST_SCHED_ARGMAX_EN
  logic [AW-1:0] max_idx; logic [31:0] max_val;
  logic [0:0] max_idx1;   logic [31:0] max_val1;
`endif

  always #5 clk = ~clk;

  mnist_dlayer1_sched #(.N_NODES(N), .AW(AW), .NODE_LAT(L)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .x_in(x_in), .busy(busy), .done(done),
    .err(err), .w_rd(w_rd), .w_addr(w_addr), .w_data(w_data), .b_data(b_data),
    .node_valid(node_valid), .node_a(node_a), .node_b(node_b), .node_bias(node_bias),
    .node_c(node_c), .node_v(node_v), .res_wr(res_wr), .res_addr(res_addr),
    .res_data(res_data)
`ifdef MNIST_SCHED_ARGMAX_EN
    , .max_idx(max_idx), .max_val(max_val)
`endif
  );

  mnist_dlayer1_sched #(.N_NODES(1), .AW(1), .NODE_LAT(L)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start), .x_in(x_in), .busy(busy1), .done(done1),
    .err(err1), .w_rd(w_rd1), .w_addr(w_addr1), .w_data(w_data1), .b_data(b_data1),
    .node_valid(node_valid1), .node_a(node_a1), .node_b(node_b1), .node_bias(node_bias1),
    .node_c(node_c1), .node_v(node_v1), .res_wr(res_wr1), .res_addr(res_addr1),
    .res_data(res_data1)
`ifdef MNIST_SCHED_ARGMAX_EN
    , .max_idx(max_idx1), .max_val(max_val1)
`endif
  );

  // Fake dense node result: mixes bias, both ends of the weight row and activation.
  function automatic logic [31:0] node_fn(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                          input logic [31:0] bias);
    return bias + b[31:0] + b[DW-1 -: 32] + a[31:0] + a[DW-1 -: 32];
  endfunction

  // Weight / bias ROM with one-cycle read latency, shared by both instances.
  logic [DW-1:0] w_mem [N];
  logic [31:0]   b_mem [N];
  always @(posedge clk) begin
    if (w_rd)  begin w_data  <= w_mem[w_addr];  b_data  <= b_mem[w_addr];  end
    if (w_rd1) begin w_data1 <= w_mem[w_addr1]; b_data1 <= b_mem[w_addr1]; end
  end

  // Dense node models: fixed latency L, flushed by the shared reset.
  logic [L-1:0] pv, pv1;
  logic [31:0]  pc [L];
  logic [31:0]  pc1 [L];
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pv  <= '0;
      pv1 <= '0;
    end else begin
      pv     <= {pv[L-2:0], node_valid};
      pv1    <= {pv1[L-2:0], node_valid1};
      pc[0]  <= node_fn(node_a, node_b, node_bias);
      pc1[0] <= node_fn(node_a1, node_b1, node_bias1);
      for (int k = 1; k < L; k++) begin
        pc[k]  <= pc[k-1];
        pc1[k] <= pc1[k-1];
      end
    end
  end
  assign node_v  = pv[L-1] | inj_v;
  assign node_c  = pc[L-1];
  assign node_v1 = pv1[L-1];
  assign node_c1 = pc1[L-1];

  int n_checks = 0;
  int n_pass   = 0;

  // Per-pass observations: bit c of each vector is the signal in cycle c after start.
  logic [31:0] o_busy, o_wrd, o_nv, o_rwr, o_done, o_err;
  logic [31:0] o1_wrd, o1_nv, o1_rwr, o1_done;
  logic [AW-1:0] got_addr [$];
  logic [31:0]   got_data [$];
  logic [0:0]    got1_addr [$];
  logic [31:0]   got1_data [$];
  logic [DW-1:0] x_sent, o_node_a;
  logic [31:0]   exp_data [N];
`ifdef MNIST_SCHED_ARGMAX_EN
  logic [AW-1:0] o_max_idx; logic [31:0] o_max_val;
`endif

  function automatic logic [31:0] win(input int lo, input int hi);
    logic [31:0] v;
    v = '0;
    for (int i = lo; i <= hi; i++) v[i] = 1'b1;
    return v;
  endfunction

  task automatic rand_wide(output logic [DW-1:0] v);
    for (int k = 0; k < DW / 32; k++) v[k*32 +: 32] = $urandom;
  endtask

  task automatic rand_mem;
    for (int i = 0; i < N; i++) begin
      rand_wide(w_mem[i]);
      b_mem[i] = $urandom;
    end
  endtask

  // Expected buffer contents: one node result per weight row, in row order.
  task automatic build_expect;
    for (int i = 0; i < N; i++) exp_data[i] = node_fn(x_sent, w_mem[i], b_mem[i]);
  endtask

  // Starts a pass from a negedge and records ncyc cycles; x_in is scrambled after start.
  task automatic run_pass(input int ncyc, input bit extra_starts, input bit zero_x);
    o_busy = '0; o_wrd = '0; o_nv = '0; o_rwr = '0; o_done = '0; o_err = '0;
    o1_wrd = '0; o1_nv = '0; o1_rwr = '0; o1_done = '0;
    got_addr.delete(); got_data.delete(); got1_addr.delete(); got1_data.delete();
    if (zero_x) x_sent = '0; else rand_wide(x_sent);
    x_in  = x_sent;
    start = 1'b1;
    @(posedge clk);
    for (int c = 1; c <= ncyc; c++) begin
      @(negedge clk);
      o_busy[c] = busy; o_wrd[c] = w_rd; o_nv[c] = node_valid;
      o_rwr[c] = res_wr; o_done[c] = done; o_err[c] = err;
      o1_wrd[c] = w_rd1; o1_nv[c] = node_valid1; o1_rwr[c] = res_wr1; o1_done[c] = done1;
      if (res_wr)  begin got_addr.push_back(res_addr);   got_data.push_back(res_data);   end
      if (res_wr1) begin got1_addr.push_back(res_addr1); got1_data.push_back(res_data1); end
      if (c == 5) o_node_a = node_a;
`ifdef MNIST_SCHED_ARGMAX_EN
      if (done) begin o_max_idx = max_idx; o_max_val = max_val; end
`endif
      rand_wide(x_in);
      start = extra_starts && (c == 3 || c == TDONE);
    end
    start = 1'b0;
    build_expect();
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    start = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++;
    if ({busy, done, err, w_rd, node_valid, res_wr} !== 6'b0) begin
      $display("FAIL reset_ctrl: got %b expected 000000", {busy, done, err, w_rd, node_valid, res_wr});
    end else n_pass++;
    n_checks++;
    if ({w_addr, res_addr, res_data, node_bias} !== '0) begin
      $display("FAIL reset_addr_data: got w_addr=%h res_addr=%h res_data=%h bias=%h expected all 0",
               w_addr, res_addr, res_data, node_bias);
    end else n_pass++;
    n_checks++;
    if ((node_a !== '0) || (node_b !== '0)) begin
      $display("FAIL reset_node_ab: got %0d/%0d set bits expected 0/0", $countones(node_a), $countones(node_b));
    end else n_pass++;
`ifdef MNIST_SCHED_ARGMAX_EN
    n_checks++;
    if ({max_idx, max_val} !== '0) begin
      $display("FAIL reset_max: got idx=%0d val=%h expected 0/0", max_idx, max_val);
    end else n_pass++;
`endif
    rst_n = 1'b1;
    @(negedge clk);
    n_checks++;
    if (busy !== 1'b0) $display("FAIL idle_after_reset: got busy=%b expected 0", busy);
    else n_pass++;
  endtask

  task automatic test_pass_random;
    rand_mem();
    run_pass(TDONE + 1, 1'b0, 1'b0);
    n_checks++;
    if (o_busy !== win(1, TDONE)) $display("FAIL busy_window: got %h expected %h", o_busy, win(1, TDONE));
    else n_pass++;
    n_checks++;
    if (o_wrd !== win(1, N)) $display("FAIL w_rd_window: got %h expected %h", o_wrd, win(1, N));
    else n_pass++;
    n_checks++;
    if (o_nv !== win(2, N + 1)) $display("FAIL node_valid_window: got %h expected %h", o_nv, win(2, N + 1));
    else n_pass++;
    n_checks++;
    if (o_rwr !== win(2 + L, N + 1 + L)) $display("FAIL res_wr_window: got %h expected %h", o_rwr, win(2 + L, N + 1 + L));
    else n_pass++;
    n_checks++;
    if (o_done !== win(TDONE, TDONE)) $display("FAIL done_pulse: got %h expected %h", o_done, win(TDONE, TDONE));
    else n_pass++;
    n_checks++;
    if (o_err !== '0) $display("FAIL err_clean_pass: got %h expected 0", o_err);
    else n_pass++;
    n_checks++;
    if (o_node_a !== x_sent) $display("FAIL node_a_latched: got low word %h expected %h", o_node_a[31:0], x_sent[31:0]);
    else n_pass++;
    n_checks++;
    if (got_data.size() != N) $display("FAIL write_count: got %0d expected %0d", got_data.size(), N);
    else n_pass++;
    for (int i = 0; i < N && i < got_data.size(); i++) begin
      n_checks++;
      if (got_addr[i] !== AW'(i) || got_data[i] !== exp_data[i])
        $display("FAIL result_%0d: got addr=%0d data=%h expected addr=%0d data=%h", i, got_addr[i], got_data[i], i, exp_data[i]);
      else n_pass++;
    end
`ifdef MNIST_SCHED_ARGMAX_EN
    begin
      int best;
      best = 0;
      for (int i = 1; i < N; i++) if ($signed(exp_data[i]) > $signed(exp_data[best])) best = i;
      n_checks++;
      if (o_max_idx !== AW'(best) || o_max_val !== exp_data[best])
        $display("FAIL argmax_random: got idx=%0d val=%h expected idx=%0d val=%h", o_max_idx, o_max_val, best, exp_data[best]);
      else n_pass++;
    end
`endif
  endtask

  task automatic test_argmax;
    for (int i = 0; i < N; i++) w_mem[i] = '0;
    b_mem[0] = 32'd5; b_mem[1] = 32'd12; b_mem[2] = 32'd3; b_mem[3] = 32'd12;
    run_pass(TDONE + 1, 1'b0, 1'b1);
    n_checks++;
    if (got_data.size() != N) $display("FAIL argmax_count: got %0d expected %0d", got_data.size(), N);
    else n_pass++;
    for (int i = 0; i < N && i < got_data.size(); i++) begin
      n_checks++;
      if (got_data[i] !== b_mem[i]) $display("FAIL argmax_buf_%0d: got %0d expected %0d", i, got_data[i], b_mem[i]);
      else n_pass++;
    end
`ifdef MNIST_SCHED_ARGMAX_EN
    n_checks++;
    if (o_max_idx !== AW'(1) || o_max_val !== 32'd12)
      $display("FAIL argmax_tie: got idx=%0d val=%0d expected idx=1 val=12", o_max_idx, o_max_val);
    else n_pass++;
`endif
  endtask

  task automatic test_single_node;
    rand_mem();
    run_pass(TDONE + 1, 1'b0, 1'b0);
    n_checks++;
    if ({o1_wrd, o1_nv, o1_rwr, o1_done} !== {win(1, 1), win(2, 2), win(2 + L, 2 + L), win(3 + L, 3 + L)})
      $display("FAIL single_timing: got %h %h %h %h expected %h %h %h %h", o1_wrd, o1_nv, o1_rwr, o1_done,
               win(1, 1), win(2, 2), win(2 + L, 2 + L), win(3 + L, 3 + L));
    else n_pass++;
    n_checks++;
    if (got1_data.size() != 1) $display("FAIL single_count: got %0d expected 1", got1_data.size());
    else if (got1_addr[0] !== 1'b0 || got1_data[0] !== exp_data[0])
      $display("FAIL single_result: got addr=%0d data=%h expected addr=0 data=%h", got1_addr[0], got1_data[0], exp_data[0]);
    else n_pass++;
  endtask

  task automatic test_err;
    @(negedge clk);
    inj_v = 1'b1;
    #1;
    n_checks++;
    if (res_wr !== 1'b0) $display("FAIL idle_node_v_no_write: got res_wr=%b expected 0", res_wr);
    else n_pass++;
    @(negedge clk);
    inj_v = 1'b0;
    n_checks++;
    if (err !== 1'b1) $display("FAIL err_set: got %b expected 1", err);
    else n_pass++;
    @(negedge clk);
    n_checks++;
    if (err !== 1'b1) $display("FAIL err_sticky: got %b expected 1", err);
    else n_pass++;
    rand_mem();
    run_pass(TDONE + 1, 1'b0, 1'b0);
    n_checks++;
    if (o_err !== '0) $display("FAIL err_cleared_by_start: got %h expected 0", o_err);
    else n_pass++;
    n_checks++;
    if (got_data.size() != N || got_addr[0] !== '0 || got_data[N-1] !== exp_data[N-1])
      $display("FAIL err_following_pass: got %0d writes expected %0d", got_data.size(), N);
    else n_pass++;
  endtask

  task automatic test_back_to_back;
    for (int p = 0; p < 2; p++) begin
      rand_mem();
      run_pass(TDONE + 1, (p == 0), 1'b0);
      n_checks++;
      if ({o_busy, o_wrd, o_rwr, o_done} !== {win(1, TDONE), win(1, N), win(2 + L, N + 1 + L), win(TDONE, TDONE)})
        $display("FAIL b2b_timing_%0d: got %h %h %h %h expected %h %h %h %h", p, o_busy, o_wrd, o_rwr, o_done,
                 win(1, TDONE), win(1, N), win(2 + L, N + 1 + L), win(TDONE, TDONE));
      else n_pass++;
      n_checks++;
      if (got_data.size() != N) $display("FAIL b2b_count_%0d: got %0d expected %0d", p, got_data.size(), N);
      else n_pass++;
      for (int i = 0; i < N && i < got_data.size(); i++) begin
        n_checks++;
        if (got_addr[i] !== AW'(i) || got_data[i] !== exp_data[i])
          $display("FAIL b2b_result_%0d_%0d: got addr=%0d data=%h expected addr=%0d data=%h", p, i,
                   got_addr[i], got_data[i], i, exp_data[i]);
        else n_pass++;
      end
    end
  endtask

  task automatic test_reset_midpass;
    rand_mem();
    run_pass(6, 1'b0, 1'b0);
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({busy, done, err, w_rd, node_valid, res_wr} !== 6'b0 || {w_addr, res_addr, res_data, node_bias} !== '0)
      $display("FAIL midpass_reset_ctrl: got ctrl=%b w_addr=%0d res_addr=%0d expected all 0",
               {busy, done, err, w_rd, node_valid, res_wr}, w_addr, res_addr);
    else n_pass++;
    n_checks++;
    if ((node_a !== '0) || (node_b !== '0))
      $display("FAIL midpass_reset_node_ab: got %0d/%0d set bits expected 0/0", $countones(node_a), $countones(node_b));
    else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    rand_mem();
    run_pass(TDONE + 1, 1'b0, 1'b0);
    n_checks++;
    if ({o_busy, o_rwr, o_done} !== {win(1, TDONE), win(2 + L, N + 1 + L), win(TDONE, TDONE)})
      $display("FAIL post_reset_timing: got %h %h %h expected %h %h %h", o_busy, o_rwr, o_done,
               win(1, TDONE), win(2 + L, N + 1 + L), win(TDONE, TDONE));
    else n_pass++;
    n_checks++;
    if (got_data.size() != N) $display("FAIL post_reset_count: got %0d expected %0d", got_data.size(), N);
    else n_pass++;
    for (int i = 0; i < N && i < got_data.size(); i++) begin
      n_checks++;
      if (got_addr[i] !== AW'(i) || got_data[i] !== exp_data[i])
        $display("FAIL post_reset_result_%0d: got addr=%0d data=%h expected addr=%0d data=%h", i,
                 got_addr[i], got_data[i], i, exp_data[i]);
      else n_pass++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_pass_random();
    test_argmax();
    test_single_node();
    test_err();
    test_back_to_back();
    test_reset_midpass();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
